// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// lane widths and the alignment rule.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Encoding 3 is reserved and behaves as a full word.
  function automatic lsu_size_e norm_size(input logic [1:0] raw);
    lsu_size_e sz;
    sz = (raw == 2'd3) ? SZ_WORD : lsu_size_e'(raw);
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: load extraction with sign/zero extension,
// and store merge of a byte/half into an existing memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e         i_ld_size,
  input  logic [1:0]        i_ld_lane,
  input  logic              i_ld_unsigned,
  input  logic [WORD_W-1:0] i_ld_word,
  output logic [WORD_W-1:0] o_ld_data,
  input  lsu_size_e         i_st_size,
  input  logic [1:0]        i_st_lane,
  input  logic [HALF_W-1:0] i_st_wdata,
  input  logic [WORD_W-1:0] i_st_word,
  output logic [WORD_W-1:0] o_st_word
);

  logic [WORD_W-1:0] w_ld_shift;
  logic              w_sign_b;
  logic              w_sign_h;
  logic [WORD_W-1:0] w_st_mask;
  logic [WORD_W-1:0] w_st_data;

  // Load: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_ld_shift = i_ld_word >> {i_ld_lane, 3'b000};
    w_sign_b   = !i_ld_unsigned && w_ld_shift[BYTE_W-1];
    w_sign_h   = !i_ld_unsigned && w_ld_shift[HALF_W-1];
    o_ld_data  = w_ld_shift;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{(WORD_W-BYTE_W){w_sign_b}}, w_ld_shift[BYTE_W-1:0]};
      SZ_HALF: o_ld_data = {{(WORD_W-HALF_W){w_sign_h}}, w_ld_shift[HALF_W-1:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

  // Store: replicate the data across all lanes and let the mask pick the target.
  always_comb begin
    w_st_mask = '0;
    w_st_data = '0;
    case (i_st_size)
      SZ_BYTE: begin
        w_st_mask = WORD_W'({BYTE_W{1'b1}}) << {i_st_lane, 3'b000};
        w_st_data = {(WORD_W/BYTE_W){i_st_wdata[BYTE_W-1:0]}};
      end
      SZ_HALF: begin
        w_st_mask = WORD_W'({HALF_W{1'b1}}) << {i_st_lane, 3'b000};
        w_st_data = {(WORD_W/HALF_W){i_st_wdata}};
      end
      default: begin
        w_st_mask = '0;
        w_st_data = '0;
      end
    endcase
    o_st_word = (i_st_word & ~w_st_mask) | (w_st_data & w_st_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline request/response handshake and a
// word-addressed memory with combinational read; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [BITS-1:0]          req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BITS-1:0]          rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_write_en,
  output logic [$clog2(DEPTH)-1:0] mem_write_address,
  output logic [BITS-1:0]          mem_data_in,
  output logic [$clog2(DEPTH)-1:0] mem_read_address,
  input  logic [BITS-1:0]          mem_data_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;

  logic [AW-1:0]     r_idx;
  logic [1:0]        r_lane;
  lsu_size_e         r_size;
  logic [HALF_W-1:0] r_wdata;
  logic [AW-1:0]     r_wr_addr;
  logic [BITS-1:0]   r_wr_data;
  logic [BITS-1:0]   r_rdata;
  logic              r_err;

  lsu_size_e         w_req_size;
  logic [AW-1:0]     w_req_idx;
  logic              w_accept;
  logic              w_misaligned;
  logic [WORD_W-1:0] w_ld_data;
  logic [WORD_W-1:0] w_merge_word;
  logic              w_unused_addr;

  // Upper address bits beyond the memory depth wrap by design.
  assign w_unused_addr = ^req_addr[31:AW+2];

  assign w_req_size   = norm_size(req_size);
  assign w_req_idx    = req_addr[AW+1:2];
  assign w_misaligned = is_misaligned(w_req_size, req_addr[1:0]);
  assign w_accept     = req_valid && (r_state == ST_IDLE);

  lsu_lane_align u_lane_align (
    .i_ld_size     (w_req_size),
    .i_ld_lane     (req_addr[1:0]),
    .i_ld_unsigned (req_unsigned),
    .i_ld_word     (mem_data_out),
    .o_ld_data     (w_ld_data),
    .i_st_size     (r_size),
    .i_st_lane     (r_lane),
    .i_st_wdata    (r_wdata),
    .i_st_word     (mem_data_out),
    .o_st_word     (w_merge_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned || !req_write) begin
            w_state_nxt = ST_RESP;
          end else if (w_req_size == SZ_WORD) begin
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_MERGE;
          end
        end
      end
      ST_MERGE: w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, merge result and response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_lane    <= '0;
      r_size    <= SZ_BYTE;
      r_wdata   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_req_idx;
            r_lane  <= req_addr[1:0];
            r_size  <= w_req_size;
            r_wdata <= req_wdata[HALF_W-1:0];
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (!req_write) begin
              r_rdata <= BITS'(w_ld_data);
            end else if (w_req_size == SZ_WORD) begin
              r_wr_addr <= w_req_idx;
              r_wr_data <= req_wdata;
            end
          end
        end
        ST_MERGE: begin
          r_wr_addr <= r_idx;
          r_wr_data <= BITS'(w_merge_word);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready         = (r_state == ST_IDLE);
  assign rsp_valid         = (r_state == ST_RESP);
  assign rsp_rdata         = r_rdata;
  assign rsp_err           = r_err;
  assign mem_write_en      = (r_state == ST_WRITE) && !rst;
  assign mem_write_address = r_wr_addr;
  assign mem_data_in       = r_wr_data;
  assign mem_read_address  = (r_state == ST_IDLE) ? w_req_idx : r_idx;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// random traffic checked against a byte-level reference memory model.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_address;
  logic [31:0]   mem_data_in;
  logic [AW-1:0] mem_read_address;
  logic [31:0]   mem_data_out;

  logic [31:0]   tb_mem  [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic          poke_en;
  logic [AW-1:0] poke_idx;
  logic [31:0]   poke_val;
  int            wr_count = 0;
  int            n_cmp    = 0;
  int            n_fail   = 0;

  load_store_unit #(.BITS(32), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .mem_write_en      (mem_write_en),
    .mem_write_address (mem_write_address),
    .mem_data_in       (mem_data_in),
    .mem_read_address  (mem_read_address),
    .mem_data_out      (mem_data_out)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, posedge write, plus a preload port.
  assign mem_data_out = tb_mem[mem_read_address];

  always @(posedge clk) begin
    if (poke_en) begin
      tb_mem[poke_idx] <= poke_val;
    end else if (mem_write_en) begin
      tb_mem[mem_write_address] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: each access touches 1/2/4 bytes starting at the byte lane.
  task automatic model(input logic wr, input logic [1:0] sz_raw, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_err,
                       output int e_lat, output int e_wr);
    int sz;
    int nb;
    int lane;
    int idx;
    logic [31:0] w;
    logic [31:0] v;
    sz    = (sz_raw == 2'd3) ? 2 : int'(sz_raw);
    nb    = 1 << sz;
    lane  = int'(addr[1:0]);
    idx   = int'(addr[AW+1:2]);
    e_rd  = 32'h0;
    e_err = 1'b0;
    e_wr  = 0;
    e_lat = 1;
    if ((lane % nb) != 0) begin
      e_err = 1'b1;
    end else if (!wr) begin
      w = ref_mem[idx];
      v = 32'h0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = w[8*(lane+k) +: 8];
      if (!uns) begin
        for (int k = nb; k < 4; k++) v[8*k +: 8] = {8{v[8*nb-1]}};
      end
      e_rd = v;
    end else begin
      w = ref_mem[idx];
      for (int k = 0; k < nb; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
      ref_mem[idx] = w;
      e_wr  = 1;
      e_lat = (nb == 4) ? 2 : 3;
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] obs_rd);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_wr;
    int          lat;
    int          wc0;
    int          idx;
    model(wr, sz, uns, addr, wd, e_rd, e_err, e_lat, e_wr);
    idx          = int'(addr[AW+1:2]);
    wc0          = wr_count;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'h1);
    check("idle_rd_addr", 32'(mem_read_address), 32'(idx));
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(e_lat));
    check("rsp_rdata", rsp_rdata, e_rd);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    obs_rd = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_rdata", rsp_rdata, e_rd);
      check("hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'h0);
    check("post_req_ready", 32'(req_ready), 32'h1);
    check("post_rdata_zero", rsp_rdata, 32'h0);
    check("write_pulses", 32'(wr_count - wc0), 32'(e_wr));
    if (e_wr != 0) check("mem_word", tb_mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] rd;
    int          wc0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    poke_en      = 1'b0;
    poke_idx     = '0;
    poke_val     = 32'h0;

    // Preload memory while held in reset.
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = $urandom;
      if (i == 3) ref_mem[i] = 32'h8899AABB;
      if (i == 5) ref_mem[i] = 32'h11223344;
      if (i == 7) ref_mem[i] = 32'h76543210;
      if (i == 9) ref_mem[i] = 32'h0BADBEEF;
      poke_en  = 1'b1;
      poke_idx = AW'(i);
      poke_val = ref_mem[i];
      @(posedge clk); #1;
    end
    poke_en = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_write_en), 32'h0);
    check("rst_wr_addr", 32'(mem_write_address), 32'h0);
    check("rst_wr_data", mem_data_in, 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed and unsigned byte loads from word 3.
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'h0, 0, rd);
    check("byte_signed_const", rd, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_000D, 32'h0, 0, rd);
    check("byte_unsigned_const", rd, 32'h0000_00AA);

    // Half store into word 5 via read-modify-write.
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'h0000_BEEF, 0, rd);
    check("half_store_const", tb_mem[5], 32'hBEEF_3344);

    // Misaligned word load.
    wc0 = wr_count;
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0402, 32'h0, 0, rd);
    check("misaligned_rdata_const", rd, 32'h0);
    check("misaligned_no_write", 32'(wr_count - wc0), 32'h0);

    // Response backpressure for four cycles.
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0, 4, rd);
    check("backpressure_const", rd, 32'hBEEF_3344);

    // Reset during MERGE of a byte store to word 7.
    wc0          = wr_count;
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_001D;
    req_wdata    = 32'h0000_00EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("merge_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("merge_rst_req_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("merge_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("merge_rst_no_write", 32'(wr_count - wc0), 32'h0);
    check("merge_rst_word7", tb_mem[7], 32'h7654_3210);

    // Reset while in WRITE of a word store to word 9 must suppress the strobe.
    wc0          = wr_count;
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd2;
    req_addr     = 32'h0000_0024;
    req_wdata    = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("write_state_we", 32'(mem_write_en), 32'h1);
    rst = 1'b1;
    #1;
    check("write_rst_we_gated", 32'(mem_write_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("write_rst_no_write", 32'(wr_count - wc0), 32'h0);
    check("write_rst_word9", tb_mem[9], 32'h0BAD_BEEF);
    check("write_rst_no_rsp", 32'(rsp_valid), 32'h0);

    // Word store wraps to word 0; read back; reserved size code behaves as word.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 0, rd);
    check("wrap_word0", tb_mem[0], 32'hCAFE_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 0, rd);
    check("wrap_readback_const", rd, 32'hCAFE_F00D);
    do_req(1'b0, 2'd3, 1'b0, 32'h0000_000C, 32'h0, 0, rd);
    check("size3_word_const", rd, 32'h8899_AABB);

    // Random traffic against the reference model.
    for (int t = 0; t < 120; t++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 4095)), $urandom, int'($urandom_range(0, 2)), rd);
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      check("final_mem", tb_mem[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BITS, 32, memory word width; fixed at 32 for byte-lane logic.
REQ-002 Parameter DEPTH, 256, number of words in the attached word-addressed memory.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  pipeline request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  lsu_pkg size: BYTE=0, HALF=1, WORD=2; value 3 is treated as WORD.
REQ-009 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  pipeline accepts response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned access.
REQ-016 mem_write_en  output  1  memory write strobe.
REQ-017 mem_write_address  output  $clog2(DEPTH)  memory write word index.
REQ-018 mem_data_in  output  32  memory write data.
REQ-019 mem_read_address  output  $clog2(DEPTH)  memory read word index.
REQ-020 mem_data_out  input  32  memory read data, combinational from mem_read_address (same cycle).

Function
REQ-021 Word index SHALL be req_addr[$clog2(DEPTH)+1:2]; higher address bits are ignored (wrap); lane = req_addr[1:0].
REQ-022 Misaligned = HALF with addr[0]=1, or WORD with addr[1:0]!=0; SHALL produce rsp_err=1, rsp_rdata=0, no memory write.
REQ-023 States: IDLE, MERGE, WRITE, RESP.
REQ-024 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-025 In IDLE, mem_read_address SHALL be the word index of req_addr; in all other states, the registered request index.
REQ-026 Accepted load: rsp_rdata is captured from mem_data_out, lane-shifted and extended; IDLE->RESP; rsp_valid asserts 1 cycle after accept.
REQ-027 Accepted WORD store: IDLE->WRITE->RESP; rsp_valid 2 cycles after accept.
REQ-028 Accepted BYTE/HALF store: IDLE->MERGE->WRITE->RESP (read-modify-write); in MERGE the unit captures mem_data_out with the target lane(s) replaced by req_wdata low bits; rsp_valid 3 cycles after accept.
REQ-029 Misaligned request: IDLE->RESP directly with rsp_err=1.
REQ-030 mem_write_en SHALL be 1 only in WRITE, for exactly one cycle, gated by !rst; mem_write_address and mem_data_in are registered values, stable during WRITE.
REQ-031 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid && rsp_ready, RESP->IDLE; no new accept in that cycle.
REQ-032 Outside RESP, rsp_valid=0, rsp_err=0 and rsp_rdata=0.

Reset
REQ-033 On rst: state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_write_en=0; address/data registers=0.
REQ-034 Reset in any state SHALL abandon the operation; no memory write occurs in a cycle where rst=1, and no response is issued for the abandoned request.

Structure
REQ-035 Package lsu_pkg holds the size enum, the state enum and the lane-extraction width constants.
REQ-036 One combinational sub-module lsu_lane_align performs load extraction/extension and store lane merge; the FSM stays in load_store_unit.

Verification
REQ-037 Memory word 3 = 0x8899AABB; load BYTE signed at addr 0x0D -> rsp_rdata=0xFFFFFFAA, rsp_valid 1 cycle after accept; same access unsigned -> 0x000000AA.
REQ-038 Word 5 = 0x11223344; store HALF 0xBEEF at 0x16 -> exactly one mem_write_en pulse, word 5 = 0xBEEF3344, rsp_valid 3 cycles after accept.
REQ-039 Load WORD at 0x0000_0402 -> rsp_err=1, rsp_rdata=0, mem_write_en never asserted.
REQ-040 rsp_ready held 0 for 4 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0; after rsp_ready=1 -> IDLE next cycle.
REQ-041 rst asserted during MERGE of a BYTE store to word 7 -> word 7 unchanged, no response, req_ready=1 after reset.
REQ-042 Store WORD 0xCAFEF00D at 0x400 (DEPTH=256) -> written to word 0 (wrap), subsequent load at 0x0 returns 0xCAFEF00D.
